// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier.
// Holds the FSM state encoding and the iteration-counter width helper.
// No logic; imported by seq_multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Counter must be able to represent 0..WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Latency: start edge, WIDTH CALC edges, then one FIN edge; done is visible after edge WIDTH+1.
// No backpressure: start is only honoured in IDLE, and starts while busy are dropped.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     addend;
    logic [AW-1:0]     acc_sum;
    logic [CW-1:0]     count;
    logic              neg;
    logic              last_iter;
    logic [2*WIDTH-1:0] prod;

    // Unsigned magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
    // which still fits because the magnitude is held unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    assign last_iter = (count == CW'(WIDTH - 1));
    assign prod      = acc[2*WIDTH-1:0];

    // Partial-product add into the upper half; the extra MSB keeps the carry before the shift.
    always_comb begin
        addend  = '0;
        if (mplier[0]) begin
            addend = {1'b0, mcand, {WIDTH{1'b0}}};
        end
        acc_sum = acc + addend;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and busy decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one shift-add step per CALC cycle, sign fix-up in FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand  <= mag(a, signed_mode);
                        mplier <= mag(b, signed_mode);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum >> 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end
                FIN: begin
                    // Two's-complement negate of zero is zero, so no negative-zero case exists.
                    p    <= neg ? (~prod + 1'b1) : prod;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
